// File: rtl/data_write_buffer.sv
// data_write_buffer
//   Posted-write buffer between the L1 data cache memory-side bus and L2/main
//   memory. Cache writes are absorbed into a DEPTH-entry FIFO. Each write is
//   accepted in one cycle unless the FIFO is full. The FIFO drains to memory
//   in order. A read goes to memory only after every older write has drained,
//   so a read always sees the data of earlier writes (read-after-write order).
//
// Optional build macro: DATA_WRITE_BUFFER_FORWARD_EN
//   When this macro is defined, a read that hits the newest FIFO entry for its
//   address is served from the FIFO in the same cycle. That entry must have
//   all byte enables set.
//
// Ports
//   i_clock, i_reset           clock; synchronous active-high reset
//   i_addr/i_we/i_re/i_be/i_wdata  upstream (cache) request
//   o_rdata, o_busy            upstream read data / stall
//   o_mem_*                    registered memory request (addr, we, re, be, wdata)
//   i_mem_rdata, i_mem_busy    memory read data / stall
//   o_dbg_state, o_dbg_count   FSM state and FIFO occupancy for observation
//
// Handshake: the upstream request is held stable while o_busy=1. The request
//   is taken in the first cycle where o_busy=0. A memory request completes in
//   the cycle where its strobe is 1 and i_mem_busy=0. If i_we and i_re are
//   both 1, the request is treated as a write.
module data_write_buffer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic [ADDR_WIDTH-1:0]         i_addr,
  input  logic                          i_we,
  input  logic                          i_re,
  input  logic [DATA_WIDTH/8-1:0]       i_be,
  input  logic [DATA_WIDTH-1:0]         i_wdata,
  output logic [DATA_WIDTH-1:0]         o_rdata,
  output logic                          o_busy,
  output logic [ADDR_WIDTH-1:0]         o_mem_addr,
  output logic                          o_mem_we,
  output logic                          o_mem_re,
  output logic [DATA_WIDTH/8-1:0]       o_mem_be,
  output logic [DATA_WIDTH-1:0]         o_mem_wdata,
  input  logic [DATA_WIDTH-1:0]         i_mem_rdata,
  input  logic                          i_mem_busy,
  output logic [1:0]                    o_dbg_state,
  output logic [$clog2(DEPTH):0]        o_dbg_count
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] ONE  = (PTR_W+1)'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, READ = 2'd2, RDONE = 2'd3} state_t;

  state_t                 state_q, state_d;
  logic [PTR_W-1:0]       head_q, tail_q, head_nxt;
  logic [PTR_W:0]         count_q;
  logic                   push, pop;

  logic [ADDR_WIDTH-1:0]  fifo_addr [DEPTH];
  logic [BE_W-1:0]        fifo_be   [DEPTH];
  logic [DATA_WIDTH-1:0]  fifo_data [DEPTH];

  logic [ADDR_WIDTH-1:0]  mem_addr_d;
  logic                   mem_we_d, mem_re_d;
  logic [BE_W-1:0]        mem_be_d;
  logic [DATA_WIDTH-1:0]  mem_wdata_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;

  logic                   fwd_hit;
  logic [DATA_WIDTH-1:0]  fwd_data;

  assign head_nxt = head_q + PTR_W'(1);

  // The head write leaves the FIFO when its memory transfer completes.
  assign pop  = (state_q == WRITE) && o_mem_we && !i_mem_busy;
  // A slot freed by pop in the same cycle can take the incoming write.
  assign push = i_we && ((count_q != FULL) || pop);

`ifdef DATA_WRITE_BUFFER_FORWARD_EN
  logic                   fwd_match, fwd_full;
  logic [PTR_W-1:0]       fwd_idx;

  // Scan the entries from oldest to newest. The last match found is the
  // newest write to that address, so it decides whether forwarding is
  // possible.
  always_comb begin
    fwd_match = 1'b0;
    fwd_full  = 1'b0;
    fwd_data  = '0;
    fwd_idx   = head_q;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = head_q + PTR_W'(k);
      if (((PTR_W+1)'(k) < count_q) && (fifo_addr[fwd_idx] == i_addr)) begin
        fwd_match = 1'b1;
        fwd_full  = &fifo_be[fwd_idx];
        fwd_data  = fifo_data[fwd_idx];
      end
    end
    fwd_hit = i_re && !i_we && fwd_match && fwd_full &&
              ((state_q == IDLE) || (state_q == WRITE));
  end
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

  assign o_rdata     = fwd_hit ? fwd_data : rdata_q;
  assign o_dbg_state = state_q;
  assign o_dbg_count = count_q;

  always_comb begin
    o_busy = 1'b0;
    if (i_we)      o_busy = !push;
    else if (i_re) o_busy = !((state_q == RDONE) || fwd_hit);
  end

  always_comb begin
    state_d     = state_q;
    mem_addr_d  = o_mem_addr;
    mem_we_d    = o_mem_we;
    mem_re_d    = o_mem_re;
    mem_be_d    = o_mem_be;
    mem_wdata_d = o_mem_wdata;
    rdata_d     = rdata_q;
    case (state_q)
      IDLE: begin
        // Pending writes always go before a read.
        if (count_q != '0) begin
          state_d     = WRITE;
          mem_we_d    = 1'b1;
          mem_re_d    = 1'b0;
          mem_addr_d  = fifo_addr[head_q];
          mem_be_d    = fifo_be[head_q];
          mem_wdata_d = fifo_data[head_q];
        end else if (i_re && !i_we) begin
          state_d    = READ;
          mem_re_d   = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = i_addr;
          mem_be_d   = '1;
        end
      end
      WRITE: begin
        if (pop) begin
          if (count_q > ONE) begin
            mem_addr_d  = fifo_addr[head_nxt];
            mem_be_d    = fifo_be[head_nxt];
            mem_wdata_d = fifo_data[head_nxt];
          end else if (push) begin
            // The only remaining entry is the one being pushed now. Its
            // storage is not written yet, so take it from the inputs.
            mem_addr_d  = i_addr;
            mem_be_d    = i_be;
            mem_wdata_d = i_wdata;
          end else begin
            state_d  = IDLE;
            mem_we_d = 1'b0;
          end
        end
      end
      READ: begin
        if (o_mem_re && !i_mem_busy) begin
          state_d  = RDONE;
          mem_re_d = 1'b0;
          rdata_d  = i_mem_rdata;
        end
      end
      RDONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q     <= IDLE;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      o_mem_addr  <= '0;
      o_mem_we    <= 1'b0;
      o_mem_re    <= 1'b0;
      o_mem_be    <= '0;
      o_mem_wdata <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      o_mem_addr  <= mem_addr_d;
      o_mem_we    <= mem_we_d;
      o_mem_re    <= mem_re_d;
      o_mem_be    <= mem_be_d;
      o_mem_wdata <= mem_wdata_d;
      rdata_q     <= rdata_d;
      if (push) tail_q <= tail_q + PTR_W'(1);
      if (pop)  head_q <= head_nxt;
      case ({push, pop})
        2'b10:   count_q <= count_q + ONE;
        2'b01:   count_q <= count_q - ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage needs no reset, because the occupancy count marks which
  // entries are valid.
  always_ff @(posedge i_clock) begin
    if (push) begin
      fifo_addr[tail_q] <= i_addr;
      fifo_be[tail_q]   <= i_be;
      fifo_data[tail_q] <= i_wdata;
    end
  end

endmodule

// File: tb/tb_data_write_buffer.sv
module tb_data_write_buffer;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int EW = AW + BW + DW;

  logic          i_clock, i_reset;
  logic [AW-1:0] i_addr;
  logic          i_we, i_re;
  logic [BW-1:0] i_be;
  logic [DW-1:0] i_wdata;
  logic [DW-1:0] o_rdata;
  logic          o_busy;
  logic [AW-1:0] o_mem_addr;
  logic          o_mem_we, o_mem_re;
  logic [BW-1:0] o_mem_be;
  logic [DW-1:0] o_mem_wdata;
  logic [DW-1:0] i_mem_rdata;
  logic          i_mem_busy;
  logic [1:0]    o_dbg_state;
  logic [2:0]    o_dbg_count;

  int checks = 0;
  int failures = 0;
  int wr_seen = 0;
  int rd_seen = 0;
  int proto_err = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_e;

  data_write_buffer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(4)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_addr(i_addr), .i_we(i_we),
    .i_re(i_re), .i_be(i_be), .i_wdata(i_wdata), .o_rdata(o_rdata),
    .o_busy(o_busy), .o_mem_addr(o_mem_addr), .o_mem_we(o_mem_we),
    .o_mem_re(o_mem_re), .o_mem_be(o_mem_be), .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(i_mem_rdata), .i_mem_busy(i_mem_busy),
    .o_dbg_state(o_dbg_state), .o_dbg_count(o_dbg_count)
  );

  // clock / reset
  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Memory-side scoreboard: every completed write must match the next expected entry
  always @(posedge i_clock) begin
    if (i_we && i_re) proto_err++;
    if (!i_reset && o_mem_we && !i_mem_busy) begin
      wr_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL mem_write_unexpected: got addr=%h be=%h data=%h, required no write",
                 o_mem_addr, o_mem_be, o_mem_wdata);
      end else begin
        exp_e = exp_q.pop_front();
        if ({o_mem_addr, o_mem_be, o_mem_wdata} !== exp_e) begin
          failures++;
          $display("FAIL mem_write_order: got %h, required %h",
                   {o_mem_addr, o_mem_be, o_mem_wdata}, exp_e);
        end
      end
    end
    if (!i_reset && o_mem_re && !i_mem_busy) rd_seen++;
  end

  task automatic tick;
    @(posedge i_clock);
    #1;
  endtask

  task automatic test_reset;
    i_reset = 1'b1; i_we = 1'b0; i_re = 1'b0; i_addr = '0; i_be = '0;
    i_wdata = '0; i_mem_busy = 1'b0; i_mem_rdata = '0;
    tick; tick;
    @(negedge i_clock);
    checks++;
    if ({o_mem_we, o_mem_re, o_busy} !== 3'b000) begin
      failures++; $display("FAIL reset_strobes: got %b, required 000", {o_mem_we, o_mem_re, o_busy});
    end
    checks++;
    if ({o_mem_addr, o_mem_be, o_mem_wdata, o_rdata} !== '0) begin
      failures++; $display("FAIL reset_data: got addr=%h be=%h wdata=%h rdata=%h, required all 0",
                           o_mem_addr, o_mem_be, o_mem_wdata, o_rdata);
    end
    checks++;
    if (o_dbg_count !== 3'd0 || o_dbg_state !== 2'd0) begin
      failures++; $display("FAIL reset_state: got count=%0d state=%0d, required 0/0", o_dbg_count, o_dbg_state);
    end
    tick;
    i_reset = 1'b0;
  endtask

  task automatic test_fill;
    i_mem_busy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      i_we = 1'b1; i_addr = 32'h100 + 32'(4 * k); i_wdata = 32'hA0 + 32'(k); i_be = 4'hF;
      @(negedge i_clock);
      checks++;
      if (o_busy !== 1'b0) begin
        failures++; $display("FAIL fill_accept[%0d]: got busy=%b, required 0", k, o_busy);
      end
      exp_q.push_back({i_addr, i_be, i_wdata});
      tick;
    end
    i_addr = 32'h110; i_wdata = 32'hA4; i_be = 4'hF;
    @(negedge i_clock);
    checks++;
    if (o_busy !== 1'b1 || o_dbg_count !== 3'd4) begin
      failures++; $display("FAIL fill_full: got busy=%b count=%0d, required 1/4", o_busy, o_dbg_count);
    end
    checks++;
    if (o_mem_we !== 1'b1 || o_mem_addr !== 32'h100) begin
      failures++; $display("FAIL fill_head: got we=%b addr=%h, required 1/100", o_mem_we, o_mem_addr);
    end
  endtask

  task automatic test_drain;
    tick;
    i_mem_busy = 1'b0;
    exp_q.push_back({32'h110, 4'hF, 32'hA4});
    @(negedge i_clock);
    checks++;
    if (o_busy !== 1'b0) begin
      failures++; $display("FAIL drain_stalled_accept: got busy=%b, required 0", o_busy);
    end
    tick;
    i_we = 1'b0;
    for (int k = 1; k < 5; k++) begin
      @(negedge i_clock);
      checks++;
      if (o_mem_we !== 1'b1 || o_mem_addr !== 32'h100 + 32'(4 * k)) begin
        failures++; $display("FAIL drain_b2b[%0d]: got we=%b addr=%h, required 1/%h",
                             k, o_mem_we, o_mem_addr, 32'h100 + 32'(4 * k));
      end
      tick;
    end
    @(negedge i_clock);
    checks++;
    if (o_mem_we !== 1'b0 || o_dbg_count !== 3'd0 || exp_q.size() != 0 || wr_seen != 5) begin
      failures++; $display("FAIL drain_done: got we=%b count=%0d left=%0d writes=%0d, required 0/0/0/5",
                           o_mem_we, o_dbg_count, exp_q.size(), wr_seen);
    end
  endtask

  task automatic test_read;
    int rd0;
    tick;
    rd0 = rd_seen;
    i_mem_busy = 1'b1; i_re = 1'b1; i_addr = 32'h200;
    @(negedge i_clock);
    checks++;
    if (o_busy !== 1'b1) begin
      failures++; $display("FAIL read_stall0: got busy=%b, required 1", o_busy);
    end
    tick;
    @(negedge i_clock);
    checks++;
    if (o_mem_re !== 1'b1 || o_mem_addr !== 32'h200 || o_mem_be !== 4'hF || o_busy !== 1'b1) begin
      failures++; $display("FAIL read_issue: got re=%b addr=%h be=%h busy=%b, required 1/200/f/1",
                           o_mem_re, o_mem_addr, o_mem_be, o_busy);
    end
    tick;
    @(negedge i_clock);
    checks++;
    if (o_busy !== 1'b1) begin
      failures++; $display("FAIL read_wait: got busy=%b, required 1", o_busy);
    end
    tick;
    i_mem_busy = 1'b0; i_mem_rdata = 32'hDEADBEEF;
    @(negedge i_clock);
    checks++;
    if (o_busy !== 1'b1) begin
      failures++; $display("FAIL read_complete_cycle: got busy=%b, required 1", o_busy);
    end
    tick;
    i_mem_rdata = '0;
    @(negedge i_clock);
    checks++;
    if (o_busy !== 1'b0 || o_rdata !== 32'hDEADBEEF || o_mem_re !== 1'b0) begin
      failures++; $display("FAIL read_data: got busy=%b rdata=%h re=%b, required 0/deadbeef/0",
                           o_busy, o_rdata, o_mem_re);
    end
    tick;
    i_re = 1'b0;
    @(negedge i_clock);
    checks++;
    if (rd_seen - rd0 != 1) begin
      failures++; $display("FAIL read_count: got %0d reads, required 1", rd_seen - rd0);
    end
  endtask

  task automatic test_raw;
    int rd0;
    bit bad_order;
    bit done;
    tick;
    rd0 = rd_seen;
    i_mem_busy = 1'b1;
    i_we = 1'b1; i_addr = 32'h300; i_wdata = 32'h11; i_be = 4'hF;
    @(negedge i_clock);
    checks++;
    if (o_busy !== 1'b0) begin
      failures++; $display("FAIL raw_write_accept: got busy=%b, required 0", o_busy);
    end
    exp_q.push_back({32'h300, 4'hF, 32'h11});
    tick;
    i_we = 1'b0; i_re = 1'b1;
    @(negedge i_clock);
`ifdef DATA_WRITE_BUFFER_FORWARD_EN
    checks++;
    if (o_busy !== 1'b0 || o_rdata !== 32'h11) begin
      failures++; $display("FAIL raw_forward: got busy=%b rdata=%h, required 0/11", o_busy, o_rdata);
    end
    tick;
    i_re = 1'b0; i_mem_busy = 1'b0;
    done = 1'b0;
    for (int n = 0; n < 10 && !done; n++) begin
      @(negedge i_clock);
      if (o_dbg_count == 3'd0 && o_mem_we == 1'b0) done = 1'b1;
      else tick;
    end
    checks++;
    if (!done || exp_q.size() != 0 || rd_seen != rd0) begin
      failures++; $display("FAIL raw_forward_drain: got done=%b left=%0d reads=%0d, required 1/0/0",
                           done, exp_q.size(), rd_seen - rd0);
    end
`else
    checks++;
    if (o_busy !== 1'b1) begin
      failures++; $display("FAIL raw_stall: got busy=%b, required 1", o_busy);
    end
    tick;
    @(negedge i_clock);
    checks++;
    if (o_mem_we !== 1'b1 || o_mem_re !== 1'b0 || o_busy !== 1'b1) begin
      failures++; $display("FAIL raw_write_first: got we=%b re=%b busy=%b, required 1/0/1",
                           o_mem_we, o_mem_re, o_busy);
    end
    tick;
    i_mem_busy = 1'b0; i_mem_rdata = 32'h5555_1234;
    bad_order = 1'b0; done = 1'b0;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge i_clock);
      if (o_mem_re && exp_q.size() != 0) bad_order = 1'b1;
      if (!o_busy) done = 1'b1;
      else tick;
    end
    checks++;
    if (!done || bad_order || o_rdata !== 32'h5555_1234) begin
      failures++; $display("FAIL raw_read_after_drain: got done=%b bad_order=%b rdata=%h, required 1/0/55551234",
                           done, bad_order, o_rdata);
    end
    checks++;
    if (exp_q.size() != 0 || rd_seen - rd0 != 1) begin
      failures++; $display("FAIL raw_counts: got left=%0d reads=%0d, required 0/1", exp_q.size(), rd_seen - rd0);
    end
    tick;
    i_re = 1'b0; i_mem_rdata = '0;
`endif
  endtask

  task automatic test_partial;
    int rd0;
    bit bad_order;
    bit done;
    tick;
    rd0 = rd_seen;
    i_mem_busy = 1'b1;
    i_we = 1'b1; i_addr = 32'h400; i_wdata = 32'h22; i_be = 4'h3;
    @(negedge i_clock);
    exp_q.push_back({32'h400, 4'h3, 32'h22});
    tick;
    i_we = 1'b0; i_re = 1'b1;
    @(negedge i_clock);
    checks++;
    if (o_busy !== 1'b1) begin
      failures++; $display("FAIL partial_no_forward: got busy=%b, required 1", o_busy);
    end
    tick;
    i_mem_busy = 1'b0; i_mem_rdata = 32'h77;
    bad_order = 1'b0; done = 1'b0;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge i_clock);
      if (o_mem_re && exp_q.size() != 0) bad_order = 1'b1;
      if (!o_busy) done = 1'b1;
      else tick;
    end
    checks++;
    if (!done || bad_order || o_rdata !== 32'h77 || exp_q.size() != 0 || rd_seen - rd0 != 1) begin
      failures++; $display("FAIL partial_read: got done=%b bad_order=%b rdata=%h left=%0d reads=%0d, required 1/0/77/0/1",
                           done, bad_order, o_rdata, exp_q.size(), rd_seen - rd0);
    end
    tick;
    i_re = 1'b0; i_mem_rdata = '0;
  endtask

  task automatic test_reset_inflight;
    int w0;
    tick;
    i_mem_busy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i_we = 1'b1; i_addr = 32'h500 + 32'(4 * k); i_wdata = 32'hC0 + 32'(k); i_be = 4'hF;
      @(negedge i_clock);
      checks++;
      if (o_busy !== 1'b0) begin
        failures++; $display("FAIL inflight_accept[%0d]: got busy=%b, required 0", k, o_busy);
      end
      tick;
    end
    i_we = 1'b0;
    @(negedge i_clock);
    checks++;
    if (o_mem_we !== 1'b1 || o_dbg_count !== 3'd3) begin
      failures++; $display("FAIL inflight_pending: got we=%b count=%0d, required 1/3", o_mem_we, o_dbg_count);
    end
    tick;
    i_reset = 1'b1;
    tick;
    i_reset = 1'b0; i_mem_busy = 1'b0;
    w0 = wr_seen;
    @(negedge i_clock);
    checks++;
    if (o_mem_we !== 1'b0 || o_dbg_count !== 3'd0 || o_busy !== 1'b0) begin
      failures++; $display("FAIL inflight_reset: got we=%b count=%0d busy=%b, required 0/0/0",
                           o_mem_we, o_dbg_count, o_busy);
    end
    repeat (5) tick;
    @(negedge i_clock);
    checks++;
    if (wr_seen != w0 || o_mem_we !== 1'b0) begin
      failures++; $display("FAIL inflight_no_writes: got writes=%0d we=%b, required 0/0", wr_seen - w0, o_mem_we);
    end
  endtask

  initial begin
    test_reset;
    test_fill;
    test_drain;
    test_read;
    test_raw;
    test_partial;
    test_reset_inflight;
    checks++;
    if (proto_err != 0) begin
      failures++; $display("FAIL protocol_we_re: got %0d cycles with both i_we and i_re, required 0", proto_err);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_write_buffer.md
Name: data_write_buffer

Overview:
- Posted-write buffer between the L1 data cache's memory-side bus and L2/main memory.
- Absorbs cache write-throughs and evictions into a small FIFO so the cache sees single-cycle write acceptance.
- Drains the FIFO to memory in order.
- Reads pass through to memory only once all older writes have drained, preserving RAW ordering.

Parameters:
- ADDR_WIDTH, 32, address width in bits.
- DATA_WIDTH, 32, data width in bits (multiple of 8).
- DEPTH, 4, FIFO entries (power of two, >= 2).

Ports:
- i_clock  in  1  clock.
- i_reset  in  1  synchronous reset, active-high.
- i_addr  in  ADDR_WIDTH  upstream (cache) address.
- i_we  in  1  upstream write request.
- i_re  in  1  upstream read request.
- i_be  in  DATA_WIDTH/8  upstream byte enables.
- i_wdata  in  DATA_WIDTH  upstream write data.
- o_rdata  out  DATA_WIDTH  upstream read data; valid when i_re=1 and o_busy=0.
- o_busy  out  1  upstream stall.
- o_mem_addr  out  ADDR_WIDTH  memory address.
- o_mem_we  out  1  memory write strobe.
- o_mem_re  out  1  memory read strobe.
- o_mem_be  out  DATA_WIDTH/8  memory byte enables.
- o_mem_wdata  out  DATA_WIDTH  memory write data.
- i_mem_rdata  in  DATA_WIDTH  memory read data, valid in the completion cycle.
- i_mem_busy  in  1  memory stall; a request completes in the cycle where its strobe=1 and i_mem_busy=0.

Behaviour:
- Reset (synchronous, active-high):
  - count=0, head/tail=0, state=IDLE.
  - o_mem_we/re=0; o_mem_addr/be/wdata/o_rdata=0.
  - Pending writes are discarded; a memory transfer in flight is abandoned (strobes low the cycle after reset is sampled).
- Upstream handshake: the cache holds i_addr/i_re/i_we/i_be/i_wdata stable while o_busy=1.
- i_we and i_re both 1: treated as a write, i_re ignored; the bench flags it as a protocol error.
- Write accept (combinational):
  - Accepted in the same cycle iff count<DEPTH, or a head write completes that cycle.
  - Accept means o_busy=0 and the entry {addr, be, wdata} is pushed at tail.
  - Otherwise o_busy=1.
  - Simultaneous push and pop: count unchanged.
- Count arithmetic:
  - head and tail are log2(DEPTH) bits and wrap modulo DEPTH.
  - count is log2(DEPTH)+1 bits; it never exceeds DEPTH and never underflows.
- Read path: any i_re with no forward hit gives o_busy=1 until the read-done cycle.
- FSM states: IDLE, WRITE, READ, RDONE.
  - IDLE: if count>0, go to WRITE with head entry registered onto the o_mem_* outputs (we=1). Else if i_re=1, go to READ, registering o_mem_addr=i_addr, re=1, be=all ones. Writes always take priority over reads.
  - WRITE: hold outputs while i_mem_busy=1. On completion, pop head. If count after pop >0, load the next head and stay in WRITE (back-to-back, one write per cycle at best). Else go to IDLE with strobes low.
  - READ: hold while i_mem_busy=1. On completion, register o_rdata<=i_mem_rdata, drop re, go to RDONE.
  - RDONE: o_busy=0 for i_re (data valid this cycle), then go to IDLE. Minimum read latency is 2 cycles from re to o_busy=0 with zero-wait memory.
- A read arriving while count>0 stalls until the FIFO is fully drained, including writes pushed after the read.
- Writes accepted while in READ/RDONE wait in the FIFO.
- o_mem_be/addr/wdata are don't-care when both strobes are 0, but are driven to registered values.

Optional Feature:
- Macro: DATA_WRITE_BUFFER_FORWARD_EN.
- When defined, in IDLE/WRITE with count>0, an upstream read is checked against valid entries.
  - If the newest matching-address entry has all byte enables set, o_rdata = that entry's wdata combinationally, with o_busy=0 in the same cycle and no memory access.
  - A match with partial byte enables, or no match, behaves as without the feature.
- When not defined, there is no comparator and reads always wait for drain.

Test Plan:
- Reset, then 4 writes (addr 0x100..0x10C, data 0xA0..0xA3, be=0xF) with i_mem_busy=1 -> all accepted with o_busy=0, count=4; a 5th write sees o_busy=1.
- Release i_mem_busy=0 -> memory sees writes in order 0x100, 0x104, 0x108, 0x10C on consecutive cycles; the stalled 5th write is accepted in the cycle the first write completes.
- Empty buffer, read 0x200, memory returns 0xDEADBEEF with 2 busy cycles -> o_busy=0 and o_rdata=0xDEADBEEF exactly 1 cycle after memory completion; exactly one o_mem_re transfer.
- Write 0x300 = 0x11, then read 0x300 while i_mem_busy=1 -> no o_mem_re until the write completes; read returns memory data after drain. With DATA_WRITE_BUFFER_FORWARD_EN, o_rdata=0x11 in the same cycle.
- Write with be=0x3 to 0x400, then read 0x400 with forward enabled -> no forward; read waits for drain.
- Reset asserted with 3 pending entries and o_mem_we=1 -> next cycle o_mem_we=0, count=0, o_busy=0; no further memory writes.
